// File: rtl/switch_reader.sv
// rtl/switch_reader.sv - debounced 24-bit switch input peripheral serving lw reads at the switch offsets.
// Optional SW_IRQ_EN: irq becomes a registered copy of the sticky change flag.
module switch_reader #(
  parameter int unsigned    DEBOUNCE_CYCLES = 4,
  parameter logic [15:0]    SW_ADDR_LO      = 16'hFC70,
  parameter logic [15:0]    SW_ADDR_HI      = 16'hFC72,
  parameter logic [15:0]    SW_STATUS       = 16'hFC74
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [31:0] Instruction,
  input  logic        op,
  input  logic [23:0] sw_in,
  output logic [31:0] r_data,
  output logic        r_valid,
  output logic        irq
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [5:0]  OPC_LW = 6'b100011;

  logic [23:0]   sync1_q, sync2_q, prev_q;
  logic [23:0]   stable_q, stable_d;
  logic [CW-1:0] count_q, count_d;
  logic          changed_q, changed_d;
  logic [31:0]   r_data_q, r_data_d;
  logic          r_valid_q, r_valid_d;
  logic          set_changed;
  logic          rd_lo, rd_hi, rd_st, rd_en;

  logic unused_instr;
  assign unused_instr = ^Instruction[31:16];

  assign rd_en = op && (opcode == OPC_LW);
  assign rd_lo = rd_en && (Instruction[15:0] == SW_ADDR_LO);
  assign rd_hi = rd_en && (Instruction[15:0] == SW_ADDR_HI);
  assign rd_st = rd_en && (Instruction[15:0] == SW_STATUS);

  // One counter shared by all bits: any toggle restarts the whole debounce window.
  always_comb begin
    count_d     = count_q;
    stable_d    = stable_q;
    set_changed = 1'b0;
    if (sync2_q != prev_q) begin
      count_d = '0;
    end else if (count_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      if (stable_q != sync2_q) begin
        stable_d    = sync2_q;
        set_changed = 1'b1;
      end
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  // Set has priority over the clear caused by a status read in the same cycle.
  always_comb begin
    changed_d = changed_q;
    if (rd_st)       changed_d = 1'b0;
    if (set_changed) changed_d = 1'b1;
  end

  always_comb begin
    r_data_d  = '0;
    r_valid_d = 1'b0;
    if (rd_lo) begin
      r_data_d  = {16'h0, stable_q[15:0]};
      r_valid_d = 1'b1;
    end else if (rd_hi) begin
      r_data_d  = {24'h0, stable_q[23:16]};
      r_valid_d = 1'b1;
    end else if (rd_st) begin
      r_data_d  = {31'h0, changed_q};
      r_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      stable_q  <= '0;
      count_q   <= '0;
      changed_q <= 1'b0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      sync1_q   <= sw_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      stable_q  <= stable_d;
      count_q   <= count_d;
      changed_q <= changed_d;
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
    end
  end

  assign r_data  = r_data_q;
  assign r_valid = r_valid_q;

`ifdef SW_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= changed_q;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule
